// File: rtl/riu_pkg.sv
// Shared decode types: opcodes, immediate-select encoding, control bundle, buffer states.
// Latency: n/a (types only).
// Backpressure: n/a.
package riu_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        IMM_I    = 2'b00,
        IMM_S    = 2'b01,
        IMM_NONE = 2'b10
    } imm_src_t;

    typedef struct packed {
        imm_src_t imm_src;
        logic     reg_write;
        logic     mem_write;
        logic     alu_src;
        logic     illegal;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        ctrl_t       ctrl;
    } entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_t;

endpackage

// File: rtl/riu_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready valid-ready pairs.
interface riu_decode_stage_if;
    import riu_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    imm_src_t    out_imm_src;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_reg_write;
    logic        out_mem_write;
    logic        out_alu_src;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_instr, out_imm_src, out_rd, out_rs1, out_rs2,
               out_reg_write, out_mem_write, out_alu_src, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_instr, out_imm_src, out_rd, out_rs1, out_rs2,
               out_reg_write, out_mem_write, out_alu_src, out_illegal
    );

endinterface

// File: rtl/riu_ctrl_decode.sv
// Opcode to control-bundle decoder, shared with later pipeline stages.
// Latency: combinational.
// Backpressure: none.
module riu_ctrl_decode
    import riu_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        // Unknown opcodes still flow downstream, flagged illegal with no side effects.
        ctrl = '{imm_src: IMM_NONE, reg_write: 1'b0, mem_write: 1'b0, alu_src: 1'b0, illegal: 1'b1};
        case (opcode)
            OPC_OP_IMM,
            OPC_LOAD:  ctrl = '{imm_src: IMM_I,    reg_write: 1'b1, mem_write: 1'b0, alu_src: 1'b1, illegal: 1'b0};
            OPC_STORE: ctrl = '{imm_src: IMM_S,    reg_write: 1'b0, mem_write: 1'b1, alu_src: 1'b1, illegal: 1'b0};
            OPC_OP:    ctrl = '{imm_src: IMM_NONE, reg_write: 1'b1, mem_write: 1'b0, alu_src: 1'b0, illegal: 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/riu_decode_stage.sv
// Decode stage: registers {instr, ctrl} ahead of the immediate extender, counts retired bundles.
// Latency: 1 cycle from input accept to out_valid; 1 instr/cycle sustained.
// Backpressure: 2-entry skid (main + skid); in_ready is a flop, low only when both entries are full.
module riu_decode_stage
    import riu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    riu_decode_stage_if.slave  io,
    output logic [CNT_W-1:0]   retired_cnt
);

    ctrl_t      in_ctrl;
    entry_t     in_entry;
    entry_t     main_q;
    entry_t     skid_q;
    buf_state_t state_q;
    buf_state_t state_nxt;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       in_fire;
    logic       out_fire;
    logic       load_main;
    logic       load_skid;
    logic       main_from_skid;

    riu_ctrl_decode u_ctrl_decode (
        .opcode (io.in_instr[6:0]),
        .ctrl   (in_ctrl)
    );

    assign in_entry = {io.in_instr, in_ctrl};
    assign in_fire  = io.in_valid & in_ready_q;
    assign out_fire = out_valid_q & io.out_ready;

    always_comb begin
        state_nxt      = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (in_fire) begin
                    state_nxt = BUF_ONE;
                    load_main = 1'b1;
                end
            end
            BUF_ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    state_nxt = BUF_TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                // in_ready is low here, so only the drain path can occur.
                if (out_fire) begin
                    state_nxt      = BUF_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BUF_EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
            retired_cnt <= '0;
        end else begin
            state_q     <= state_nxt;
            // Ready/valid derived from next state so both stay pure flop outputs.
            in_ready_q  <= (state_nxt != BUF_TWO);
            out_valid_q <= (state_nxt != BUF_EMPTY);
            if (load_main) begin
                main_q <= in_entry;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
            if (out_fire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    assign io.in_ready      = in_ready_q;
    assign io.out_valid     = out_valid_q;
    assign io.out_instr     = main_q.instr;
    assign io.out_imm_src   = main_q.ctrl.imm_src;
    assign io.out_rd        = main_q.instr[11:7];
    assign io.out_rs1       = main_q.instr[19:15];
    assign io.out_rs2       = main_q.instr[24:20];
    assign io.out_reg_write = main_q.ctrl.reg_write;
    assign io.out_mem_write = main_q.ctrl.mem_write;
    assign io.out_alu_src   = main_q.ctrl.alu_src;
    assign io.out_illegal   = main_q.ctrl.illegal;

endmodule
